// File: rtl/bnn_ctrl_if.sv
// Handshake/bus bundle between the BNN controller and its datapath/weight loader.
interface bnn_ctrl_if #(
  parameter int AW = 4
);
  logic          ena;
  logic          load_en;
  logic [3:0]    nibble;
  logic          start;
  logic [7:0]    x_in;
  logic [3:0]    y_in;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [7:0]    x_hold;
  logic          l1_cap;
  logic          l2_cap;
  logic          done;
  logic [3:0]    result;
  logic          busy;
  logic [7:0]    chk;

  modport master (
    output ena, load_en, nibble, start, x_in, y_in,
    input  wr_en, wr_addr, wr_data, x_hold, l1_cap, l2_cap, done, result, busy, chk
  );

  modport slave (
    input  ena, load_en, nibble, start, x_in, y_in,
    output wr_en, wr_addr, wr_data, x_hold, l1_cap, l2_cap, done, result, busy, chk
  );
endinterface

// File: rtl/bnn_ctrl.sv
// BNN sequencing controller: nibble-wise weight loading and a fixed 3-cycle inference.
// Optional feature macro: BNN_CTRL_CHKSUM_EN (XOR checksum of written weight bytes on chk).
module bnn_ctrl #(
  parameter int NUM_NEURONS = 12,
  parameter int AW          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  bnn_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LD_HI = 3'd1,
    L1    = 3'd2,
    L2    = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state_r;
  logic [AW-1:0] load_ptr_r;
  logic [3:0]    lo_buf_r;
  logic [7:0]    x_hold_r;
  logic [3:0]    result_r;
  logic          wr_en_r;
  logic [AW-1:0] wr_addr_r;
  logic [7:0]    wr_data_r;
  logic          l1_cap_r;
  logic          l2_cap_r;
  logic          done_r;
  logic          busy_r;
  logic [AW-1:0] ptr_next_s;
  logic [7:0]    byte_s;

  // Next load pointer (wrapping at the bank size) and the byte being assembled.
  always_comb begin
    ptr_next_s = load_ptr_r + AW'(1);
    if (load_ptr_r == AW'(NUM_NEURONS - 1)) begin
      ptr_next_s = {AW{1'b0}};
    end else begin
      ptr_next_s = load_ptr_r + AW'(1);
    end
    byte_s = {bus.nibble, lo_buf_r};
  end

  // Controller FSM; strobes are registered so each lines up with its state's cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      load_ptr_r <= {AW{1'b0}};
      lo_buf_r   <= 4'h0;
      x_hold_r   <= 8'h00;
      result_r   <= 4'h0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {AW{1'b0}};
      wr_data_r  <= 8'h00;
      l1_cap_r   <= 1'b0;
      l2_cap_r   <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else if (!bus.ena) begin
      // Frozen: state and data hold, strobes forced low.
      wr_en_r  <= 1'b0;
      l1_cap_r <= 1'b0;
      l2_cap_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      wr_en_r  <= 1'b0;
      l1_cap_r <= 1'b0;
      l2_cap_r <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.load_en) begin
            lo_buf_r <= bus.nibble;
            state_r  <= LD_HI;
            busy_r   <= 1'b1;
          end else if (bus.start) begin
            x_hold_r <= bus.x_in;
            l1_cap_r <= 1'b1;
            state_r  <= L1;
            busy_r   <= 1'b1;
          end else begin
            busy_r   <= 1'b0;
          end
        end
        LD_HI: begin
          if (bus.load_en) begin
            wr_en_r    <= 1'b1;
            wr_addr_r  <= load_ptr_r;
            wr_data_r  <= byte_s;
            load_ptr_r <= ptr_next_s;
            state_r    <= IDLE;
            busy_r     <= 1'b0;
          end else begin
            busy_r     <= 1'b1;
          end
        end
        L1: begin
          l2_cap_r <= 1'b1;
          state_r  <= L2;
          busy_r   <= 1'b1;
        end
        L2: begin
          // Result is captured as DONE is entered so it is valid while done is high.
          result_r <= bus.y_in;
          done_r   <= 1'b1;
          state_r  <= DONE;
          busy_r   <= 1'b1;
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BNN_CTRL_CHKSUM_EN
  logic [7:0] chk_r;

  // Checksum follows the write strobe; a write to neuron 0 restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_r <= 8'h00;
    end else if (bus.ena && (state_r == LD_HI) && bus.load_en) begin
      if (load_ptr_r == {AW{1'b0}}) begin
        chk_r <= byte_s;
      end else begin
        chk_r <= chk_r ^ byte_s;
      end
    end else begin
      chk_r <= chk_r;
    end
  end

  assign bus.chk = chk_r;
`else
  assign bus.chk = 8'h00;
`endif

  assign bus.wr_en   = wr_en_r;
  assign bus.wr_addr = wr_addr_r;
  assign bus.wr_data = wr_data_r;
  assign bus.x_hold  = x_hold_r;
  assign bus.l1_cap  = l1_cap_r;
  assign bus.l2_cap  = l2_cap_r;
  assign bus.done    = done_r;
  assign bus.result  = result_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_bnn_ctrl.sv
// Directed scoreboard bench for bnn_ctrl: weight writes and inference results are queued as expectations.
module tb_bnn_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   mdl_ptr = 0;
  logic [7:0]  mdl_chk = 8'h00;
  logic [11:0] wq[$];
  logic [3:0]  rq[$];

  bnn_ctrl_if #(.AW(4)) bus ();

  bnn_ctrl #(.NUM_NEURONS(12), .AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_chk();
`ifdef BNN_CTRL_CHKSUM_EN
    return mdl_chk;
`else
    return 8'h00;
`endif
  endfunction

  // One clock; outputs sampled on the falling edge, scoreboard popped on strobes.
  task automatic step();
    logic [11:0] w;
    logic [3:0]  r;
    @(negedge clk);
    if (bus.wr_en) begin
      if (wq.size() == 0) begin
        check("wr_unexpected", bus.wr_en, 1'b0);
      end else begin
        w = wq.pop_front();
        check("wr_addr", bus.wr_addr, w[11:8]);
        check("wr_data", bus.wr_data, w[7:0]);
      end
    end
    if (bus.done) begin
      if (rq.size() == 0) begin
        check("done_unexpected", bus.done, 1'b0);
      end else begin
        r = rq.pop_front();
        check("result", bus.result, r);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},   bus.busy,    1'b0);
    check({tag, "_wr_en"},  bus.wr_en,   1'b0);
    check({tag, "_waddr"},  bus.wr_addr, 4'h0);
    check({tag, "_wdata"},  bus.wr_data, 8'h00);
    check({tag, "_xhold"},  bus.x_hold,  8'h00);
    check({tag, "_l1"},     bus.l1_cap,  1'b0);
    check({tag, "_l2"},     bus.l2_cap,  1'b0);
    check({tag, "_done"},   bus.done,    1'b0);
    check({tag, "_result"}, bus.result,  4'h0);
    check({tag, "_chk"},    bus.chk,     8'h00);
  endtask

  task automatic load_byte(input logic [7:0] b);
    bus.load_en = 1'b1;
    bus.nibble  = b[3:0];
    step();
    bus.nibble  = b[7:4];
    wq.push_back({4'(mdl_ptr), b});
    mdl_chk = (mdl_ptr == 0) ? b : (mdl_chk ^ b);
    mdl_ptr = (mdl_ptr + 1) % 12;
    step();
    bus.load_en = 1'b0;
    check("chk", bus.chk, exp_chk());
    check("wq_drained", wq.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mdl_ptr = 0;
    mdl_chk = 8'h00;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.ena     = 1'b1;
    bus.load_en = 1'b0;
    bus.nibble  = 4'h0;
    bus.start   = 1'b0;
    bus.x_in    = 8'h00;
    bus.y_in    = 4'h0;
    step();
    step();
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // First write: nibbles B then E give EB at address 0.
    load_byte(8'hEB);
    load_byte(8'h61);
`ifdef BNN_CTRL_CHKSUM_EN
    check("chk_8a", bus.chk, 8'h8A);
`else
    check("chk_8a", bus.chk, 8'h00);
`endif

    // LD_HI holds its low nibble and ignores start while load_en is low.
    bus.load_en = 1'b1;
    bus.nibble  = 4'h3;
    step();
    bus.load_en = 1'b0;
    bus.start   = 1'b1;
    bus.x_in    = 8'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ldhi_busy", bus.busy, 1'b1);
      check("ldhi_no_l1", bus.l1_cap, 1'b0);
    end
    bus.start   = 1'b0;
    bus.load_en = 1'b1;
    bus.nibble  = 4'h7;
    wq.push_back({4'(mdl_ptr), 8'h73});
    mdl_chk = mdl_chk ^ 8'h73;
    mdl_ptr = mdl_ptr + 1;
    step();
    bus.load_en = 1'b0;
    check("ldhi_wr_seen", wq.size(), 0);
    check("ldhi_xhold", bus.x_hold, 8'h00);

    // Ten more bytes: addresses 3..11 then the wrap back to 0.
    for (int i = 0; i < 10; i++) begin
      load_byte(8'($urandom_range(0, 255)));
    end
    check("wrap_ptr_model", mdl_ptr, 1);

    // Inference: strobes at N+1, N+2, done at N+3; load/start ignored meanwhile.
    bus.start = 1'b1;
    bus.x_in  = 8'hA5;
    bus.y_in  = 4'h9;
    rq.push_back(4'h9);
    step();
    check("inf_l1", bus.l1_cap, 1'b1);
    check("inf_l1_xhold", bus.x_hold, 8'hA5);
    check("inf_l1_busy", bus.busy, 1'b1);
    bus.x_in    = 8'hFF;
    bus.load_en = 1'b1;
    bus.nibble  = 4'hC;
    step();
    check("inf_l2", bus.l2_cap, 1'b1);
    check("inf_l2_l1", bus.l1_cap, 1'b0);
    check("inf_l2_xhold", bus.x_hold, 8'hA5);
    step();
    check("inf_done", bus.done, 1'b1);
    check("inf_done_xhold", bus.x_hold, 8'hA5);
    check("inf_done_l2", bus.l2_cap, 1'b0);
    bus.start   = 1'b0;
    bus.load_en = 1'b0;
    step();
    check("inf_after_done", bus.done, 1'b0);
    check("inf_after_busy", bus.busy, 1'b0);
    check("inf_result_hold", bus.result, 4'h9);
    check("inf_rq_drained", rq.size(), 0);

    // Second inference with a different pattern.
    bus.start = 1'b1;
    bus.x_in  = 8'h3C;
    bus.y_in  = 4'h6;
    rq.push_back(4'h6);
    step();
    bus.start = 1'b0;
    step();
    step();
    check("inf2_done", bus.done, 1'b1);
    check("inf2_xhold", bus.x_hold, 8'h3C);
    step();

    // Load wins over start; then reset while in LD_HI aborts with no write.
    bus.start   = 1'b1;
    bus.load_en = 1'b1;
    bus.nibble  = 4'h5;
    bus.x_in    = 8'h11;
    step();
    bus.start   = 1'b0;
    bus.load_en = 1'b0;
    check("prio_no_l1", bus.l1_cap, 1'b0);
    check("prio_busy", bus.busy, 1'b1);
    check("prio_xhold", bus.x_hold, 8'h3C);
    step();
    step();
    check("prio_no_l1_later", bus.l1_cap, 1'b0);
    do_reset();
    check_zero("rst_ldhi");
    step();
    check("rst_ldhi_no_wr", bus.wr_en, 1'b0);

    // ena low in L2 freezes the sequence; done follows once ena returns.
    bus.start = 1'b1;
    bus.x_in  = 8'h5A;
    bus.y_in  = 4'h3;
    rq.push_back(4'h3);
    step();
    bus.start = 1'b0;
    step();
    check("frz_l2", bus.l2_cap, 1'b1);
    bus.ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_busy", bus.busy, 1'b1);
      check("frz_no_done", bus.done, 1'b0);
      check("frz_no_l2", bus.l2_cap, 1'b0);
    end
    bus.ena = 1'b1;
    step();
    check("frz_resume_done", bus.done, 1'b1);
    step();
    check("frz_rq_drained", rq.size(), 0);

    // Reset while in L2: no done pulse and every output is zero afterwards.
    bus.start = 1'b1;
    bus.x_in  = 8'h77;
    bus.y_in  = 4'hA;
    step();
    bus.start = 1'b0;
    step();
    check("rst_l2_in_l2", bus.l2_cap, 1'b1);
    do_reset();
    check_zero("rst_l2");
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_l2_no_done", bus.done, 1'b0);
    end

    // Post-reset write lands at address 0 again.
    load_byte(8'h2D);
    check("final_wq", wq.size(), 0);
    check("final_rq", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
